// File: rtl/mcac_pkg.sv
// Shared MCAC constants, the speed-control store FSM state type and the FILTC
// update helper used by the per-channel AP store.
package mcac_pkg;

   localparam int unsigned AP_W = 10;
   localparam int unsigned AL_W = 7;

   localparam logic [AP_W-1:0] AP_TRIG = 10'd256;
   localparam logic [AL_W-1:0] AL_MAX  = 7'd64;

   typedef enum logic [0:0] {INIT, RUN} state_t;

   // FILTC: AP += (((AX << 9) - AP) mod 2048) / 16, sign-extended, mod 1024.
   function automatic logic [AP_W-1:0] filtc(input logic ax, input logic [AP_W-1:0] ap);
      logic [11:0] sum;
      logic [10:0] dif;
      logic [10:0] difsx;
      logic [10:0] upd;
      sum   = {2'b00, ax, 9'd0} + 12'd2048 - {2'b00, ap};
      dif   = sum[10:0];
      difsx = dif[10] ? ({4'd0, dif[10:4]} + 11'd896) : {4'd0, dif[10:4]};
      upd   = difsx + {1'b0, ap};
      return upd[AP_W-1:0];
   endfunction

endpackage

// File: rtl/lima_calc.sv
// LIMA: limits the speed-control parameter AP to the 7-bit mixing weight AL.
module lima_calc
   import mcac_pkg::*;
(
   input  logic [AP_W-1:0] ap_i,
   output logic [AL_W-1:0] al_o
);

   always_comb begin
      al_o = (ap_i >= AP_TRIG) ? AL_MAX : {1'b0, ap_i[7:2]};
   end

endmodule

// File: rtl/apr_chan_store.sv
// Per-channel APR store: TRIGA on write, registered read of AP plus LIMA.
// Define FILTC_INT_EN to run the FILTC update internally (APP[0] carries AX).
module apr_chan_store
   import mcac_pkg::*;
#(
   parameter int unsigned NCH = 32,
   parameter int unsigned CHW = 5
) (
   input  logic            clk,
   input  logic            reset,
   output logic            rdy,
   input  logic            rd_req,
   input  logic [CHW-1:0]  rd_ch,
   output logic            rd_vld,
   output logic [AP_W-1:0] AP_OUT,
   output logic [AL_W-1:0] AL,
   input  logic            wr_vld,
   input  logic [CHW-1:0]  wr_ch,
   input  logic [AP_W-1:0] APP,
   input  logic            TR
);

   logic [AP_W-1:0] mem_q [NCH];

   state_t          state_q, state_d;
   logic [CHW-1:0]  cnt_q, cnt_d;
   logic            rd_vld_q, rd_vld_d;
   logic [AP_W-1:0] ap_q, ap_d;

   logic            wr_ok, rd_ok, wr_en, rd_en;
   logic [AP_W-1:0] app_int, apr, rd_data;

   assign wr_ok = 32'(wr_ch) < NCH;
   assign rd_ok = 32'(rd_ch) < NCH;
   assign wr_en = (state_q == RUN) && wr_vld && wr_ok;
   assign rd_en = (state_q == RUN) && rd_req;

`ifdef FILTC_INT_EN
   assign app_int = wr_ok ? filtc(APP[0], mem_q[wr_ch]) : '0;
`else
   assign app_int = APP;
`endif

   assign apr = TR ? AP_TRIG : app_int;

   // Write-first: a same-cycle write to the read channel is forwarded.
   always_comb begin
      rd_data = '0;
      if (rd_ok) begin
         rd_data = (wr_en && (wr_ch == rd_ch)) ? apr : mem_q[rd_ch];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= INIT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         INIT:    if (cnt_q == CHW'(NCH - 1)) state_d = RUN;
         RUN:     state_d = RUN;
         default: state_d = INIT;
      endcase
   end

   always_comb begin
      rdy = (state_q == RUN);
   end

   always_comb begin
      cnt_d    = (state_q == INIT) ? cnt_q + 1'b1 : cnt_q;
      rd_vld_d = rd_en;
      ap_d     = rd_en ? rd_data : ap_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q    <= '0;
         rd_vld_q <= 1'b0;
         ap_q     <= '0;
      end else begin
         cnt_q    <= cnt_d;
         rd_vld_q <= rd_vld_d;
         ap_q     <= ap_d;
      end
   end

   // Array is cleared by the init sweep rather than by reset.
   always_ff @(posedge clk) begin
      if (state_q == INIT) begin
         mem_q[cnt_q] <= '0;
      end else if (wr_en) begin
         mem_q[wr_ch] <= apr;
      end
   end

   assign rd_vld = rd_vld_q;
   assign AP_OUT = ap_q;

   lima_calc u_lima (
      .ap_i (ap_q),
      .al_o (AL)
   );

endmodule

// File: tb/tb_apr_chan_store.sv
// Scoreboard bench for apr_chan_store: reads push expectations from a channel
// model; a monitor pops and compares them whenever rd_vld pulses.
module tb_apr_chan_store;

   localparam int NCH = 32;
   localparam int CHW = 5;

   logic           clk = 1'b0;
   logic           reset;
   logic           rdy;
   logic           rd_req;
   logic [CHW-1:0] rd_ch;
   logic           rd_vld;
   logic [9:0]     AP_OUT;
   logic [6:0]     AL;
   logic           wr_vld;
   logic [CHW-1:0] wr_ch;
   logic [9:0]     APP;
   logic           TR;

   always #5 clk = ~clk;

   apr_chan_store #(.NCH(NCH), .CHW(CHW)) dut (
      .clk    (clk),
      .reset  (reset),
      .rdy    (rdy),
      .rd_req (rd_req),
      .rd_ch  (rd_ch),
      .rd_vld (rd_vld),
      .AP_OUT (AP_OUT),
      .AL     (AL),
      .wr_vld (wr_vld),
      .wr_ch  (wr_ch),
      .APP    (APP),
      .TR     (TR)
   );

   typedef struct {
      logic [9:0] ap;
      logic [6:0] al;
      string      tag;
   } exp_t;

   exp_t       sb_q[$];
   exp_t       mon_e;
   logic [9:0] model [NCH];
   logic [9:0] last_ap;
   int         n_checks = 0;
   int         n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   function automatic logic [6:0] al_of(input logic [9:0] ap);
      if (ap >= 10'd256) return 7'd64;
      return 7'(ap / 4);
   endfunction

   function automatic logic [9:0] filtc_ref(input int ax, input int ap);
      int dif, difsx;
      dif   = ((ax * 512) + 2048 - ap) % 2048;
      difsx = (dif >= 1024) ? (dif / 16) + 896 : dif / 16;
      return 10'((difsx + ap) % 1024);
   endfunction

   function automatic logic [9:0] apr_of(input logic [9:0] app, input logic tr, input int ch);
      logic [9:0] base;
`ifdef FILTC_INT_EN
      base = filtc_ref(int'(app[0]), int'(model[ch]));
`else
      base = app;
`endif
      return tr ? 10'd256 : base;
   endfunction

   // Drives one cycle of requests starting at a negedge; updates the model.
   task automatic cyc(input logic dw, input int wch, input logic [9:0] app, input logic tr,
                      input logic dr, input int rch, input string tag);
      logic [9:0] apr;
      logic [9:0] e;
      wr_vld = dw;
      wr_ch  = CHW'(wch);
      APP    = app;
      TR     = tr;
      rd_req = dr;
      rd_ch  = CHW'(rch);
      apr = (wch < NCH) ? apr_of(app, tr, wch) : 10'd0;
      if (dr) begin
         if (rch >= NCH)                   e = 10'd0;
         else if (dw && (wch == rch))      e = apr;
         else                              e = model[rch];
         sb_q.push_back('{e, al_of(e), tag});
      end
      if (dw && (wch < NCH)) model[wch] = apr;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      wr_vld = 1'b0;
      rd_req = 1'b0;
      TR     = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_rdy(output int cycles);
      cycles = 0;
      while (!rdy && cycles < 100) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      wr_vld = 1'b0;
      rd_req = 1'b0;
      @(negedge clk);
   endtask

   always @(posedge clk) begin
      #1;
      if (!reset) begin
         last_ap = 10'd0;
      end else if (rd_vld) begin
         if (sb_q.size() == 0) begin
            check_eq("spurious_rd_vld", 32'd1, 32'd0);
         end else begin
            mon_e = sb_q.pop_front();
            check_eq({mon_e.tag, "_ap"}, 32'(AP_OUT), 32'(mon_e.ap));
            check_eq({mon_e.tag, "_al"}, 32'(AL), 32'(mon_e.al));
            last_ap = mon_e.ap;
         end
      end else begin
         check_eq("hold_ap", 32'(AP_OUT), 32'(last_ap));
      end
   end

   initial begin
      int cycles;
      for (int i = 0; i < NCH; i++) model[i] = 10'd0;
      last_ap = 10'd0;
      reset  = 1'b0;
      rd_req = 1'b0;
      rd_ch  = '0;
      wr_vld = 1'b0;
      wr_ch  = '0;
      APP    = '0;
      TR     = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_rdy", 32'(rdy), 32'd0);
      check_eq("rst_rd_vld", 32'(rd_vld), 32'd0);
      check_eq("rst_ap", 32'(AP_OUT), 32'd0);
      check_eq("rst_al", 32'(AL), 32'd0);

      // Requests held during the sweep must be ignored.
      reset  = 1'b1;
      wr_vld = 1'b1;
      wr_ch  = CHW'(5);
      APP    = 10'h3FF;
      rd_req = 1'b1;
      rd_ch  = CHW'(5);
      wait_rdy(cycles);
      check_eq("init_cycles", 32'(cycles), 32'd32);
      check_eq("init_rdy", 32'(rdy), 32'd1);

      cyc(1'b0, 0, 10'h000, 1'b0, 1'b1, 5, "rd_ch5_init");
      cyc(1'b1, 3, 10'h1F0, 1'b0, 1'b0, 0, "");
      cyc(1'b0, 0, 10'h000, 1'b0, 1'b1, 3, "rd_ch3_1f0");
      cyc(1'b1, 3, 10'h0FC, 1'b0, 1'b0, 0, "");
      cyc(1'b0, 0, 10'h000, 1'b0, 1'b1, 3, "rd_ch3_0fc");
      cyc(1'b1, 6, 10'h155, 1'b0, 1'b0, 0, "");
      cyc(1'b1, 8, 10'h2AA, 1'b0, 1'b0, 0, "");
      cyc(1'b1, 7, 10'h010, 1'b1, 1'b0, 0, "");
      cyc(1'b0, 0, 10'h000, 1'b0, 1'b1, 7, "rd_ch7_trig");
      cyc(1'b0, 0, 10'h000, 1'b0, 1'b1, 6, "rd_ch6_keep");
      cyc(1'b0, 0, 10'h000, 1'b0, 1'b1, 8, "rd_ch8_keep");
      cyc(1'b1, 9, 10'h040, 1'b0, 1'b1, 9, "rd_ch9_bypass");
      cyc(1'b1, 2, 10'h0AB, 1'b0, 1'b0, 0, "");
      cyc(1'b1, 1, 10'h111, 1'b0, 1'b1, 2, "rd_ch2_old");
      cyc(1'b0, 0, 10'h000, 1'b0, 1'b1, 1, "rd_ch1_new");
      idle(3);

      // Reset, then a second reset pulse when the sweep counter is at 10.
      cyc(1'b1, 4, 10'h200, 1'b0, 1'b0, 0, "");
      cyc(1'b0, 0, 10'h000, 1'b0, 1'b1, 4, "rd_ch4_pre");
      idle(2);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < NCH; i++) model[i] = 10'd0;
      wait_rdy(cycles);
      check_eq("resweep_cycles", 32'(cycles), 32'd32);
      cyc(1'b0, 0, 10'h000, 1'b0, 1'b1, 4, "rd_ch4_cleared");

`ifdef FILTC_INT_EN
      cyc(1'b1, 0, 10'h001, 1'b0, 1'b0, 0, "");
      cyc(1'b0, 0, 10'h000, 1'b0, 1'b1, 0, "filtc_ax1_first");
      cyc(1'b1, 0, 10'h001, 1'b0, 1'b0, 0, "");
      cyc(1'b0, 0, 10'h000, 1'b0, 1'b1, 0, "filtc_ax1_second");
      check_eq("filtc_model_ap", 32'(model[0]), 32'd62);
`endif

      idle(3);
      check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
